mas_mul_acc_ctrl: RTL and testbench

MAS_MUL_ACC_CTRL -- requirements
Module: mas_mul_acc_ctrl

---
 rtl/mas_mul_acc_ctrl.sv | 156 +++++++++++++++
 tb/tb_mas_mul_acc_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mas_mul_acc_ctrl.sv
// Dot-product accumulator controller: streams operand beats into an external
// 2-edge registered multiplier, sums the returning products, and holds each vector result until it is taken.
module mas_mul_acc_ctrl #(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_a,
  input  logic [31:0]      s_b,
  input  logic             s_last,
  output logic [31:0]      mul_in1,
  output logic [31:0]      mul_in2,
  input  logic [63:0]      mul_res,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_acc,
  output logic [CNT_W-1:0] m_count,
  output logic             m_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               v0_q, v0_d, l0_q, l0_d;
  logic               v1_q, v1_d, l1_q, l1_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               m_valid_q, m_valid_d;
  logic [ACC_W-1:0]   m_acc_q, m_acc_d;
  logic [CNT_W-1:0]   m_count_q, m_count_d;
  logic               m_ovf_q, m_ovf_d;

  logic               accept;
  logic [SUM_W-1:0]   acc_sum;
  logic               cnt_sat;

  // Handshake and multiplier feed; reset and clr both block acceptance.
  always_comb begin
    s_ready = rstn && !clr && (state_q == ST_ACC);
    accept  = s_valid && s_ready;
    mul_in1 = accept ? s_a : 32'd0;
    mul_in2 = accept ? s_b : 32'd0;
    acc_sum = SUM_W'(acc_q) + SUM_W'(mul_res);
    cnt_sat = &cnt_q;
  end

  // Next-state, tag pipe, accumulator and result capture.
  always_comb begin
    state_d   = state_q;
    v0_d      = accept;
    l0_d      = accept && s_last;
    v1_d      = v0_q;
    l1_d      = l0_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    m_valid_d = m_valid_q;
    m_acc_d   = m_acc_q;
    m_count_d = m_count_q;
    m_ovf_d   = m_ovf_q;

    if (v1_q) begin
      acc_d = acc_sum[ACC_W-1:0];
      cnt_d = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
      ovf_d = ovf_q | acc_sum[ACC_W] | cnt_sat;
    end

    case (state_q)
      ST_ACC: begin
        if (accept && s_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (v1_q && l1_q) begin
          state_d   = ST_DONE;
          m_valid_d = 1'b1;
          m_acc_d   = acc_d;
          m_count_d = cnt_d;
          m_ovf_d   = ovf_d;
        end
      end
      ST_DONE: begin
        if (m_ready) begin
          state_d   = ST_ACC;
          m_valid_d = 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase

    // Abort wins over everything; in-flight products lose their tags here.
    if (clr) begin
      state_d   = ST_ACC;
      v0_d      = 1'b0;
      l0_d      = 1'b0;
      v1_d      = 1'b0;
      l1_d      = 1'b0;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      m_valid_d = 1'b0;
      m_acc_d   = '0;
      m_count_d = '0;
      m_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_ACC;
      v0_q      <= 1'b0;
      l0_q      <= 1'b0;
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_acc_q   <= '0;
      m_count_q <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      v0_q      <= v0_d;
      l0_q      <= l0_d;
      v1_q      <= v1_d;
      l1_q      <= l1_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      m_valid_q <= m_valid_d;
      m_acc_q   <= m_acc_d;
      m_count_q <= m_count_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_acc   = m_acc_q;
  assign m_count = m_count_q;
  assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_mas_mul_acc_ctrl.sv
// Directed bench for mas_mul_acc_ctrl: a 72-bit instance plus a 64-bit/2-bit-counter
// instance driven in lockstep, each fed by a 2-edge registered multiplier model.
module tb_mas_mul_acc_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr;
  logic        s_valid;
  logic [31:0] s_a, s_b;
  logic        s_last;
  logic        m_ready;

  logic        s_ready_a, s_ready_b;
  logic [31:0] mul_in1_a, mul_in2_a, mul_in1_b, mul_in2_b;
  logic [63:0] mul_res_a, mul_res_b;
  logic [63:0] p0_a = 64'd0, p0_b = 64'd0;
  logic        m_valid_a, m_valid_b;
  logic [71:0] m_acc_a;
  logic [63:0] m_acc_b;
  logic [15:0] m_count_a;
  logic [1:0]  m_count_b;
  logic        m_ovf_a, m_ovf_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mas_mul_acc_ctrl #(.ACC_W(72), .CNT_W(16)) u_a (
    .clk(clk), .rstn(rstn), .clr(clr), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .mul_in1(mul_in1_a), .mul_in2(mul_in2_a),
    .mul_res(mul_res_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_acc(m_acc_a),
    .m_count(m_count_a), .m_ovf(m_ovf_a));

  mas_mul_acc_ctrl #(.ACC_W(64), .CNT_W(2)) u_b (
    .clk(clk), .rstn(rstn), .clr(clr), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .mul_in1(mul_in1_b), .mul_in2(mul_in2_b),
    .mul_res(mul_res_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_acc(m_acc_b),
    .m_count(m_count_b), .m_ovf(m_ovf_b));

  // Registered 32x32 multiplier: product appears two edges after the operands.
  always_ff @(posedge clk) begin
    p0_a      <= 64'(mul_in1_a) * 64'(mul_in2_a);
    mul_res_a <= p0_a;
    p0_b      <= 64'(mul_in1_b) * 64'(mul_in2_b);
    mul_res_b <= p0_b;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
    n = 0;
    while (!s_ready_a && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("s_ready_timeout", 80'(s_ready_a), 80'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_a     = 32'd0;
    s_b     = 32'd0;
  endtask

  // Called right after the last beat's accept edge; expects m_valid two edges later.
  task automatic wait_done(input string name, input logic [71:0] e_acc,
                           input logic [15:0] e_cnt, input logic e_ovf);
    int lat;
    lat = 0;
    while (!m_valid_a && lat < 20) begin
      chk({name, "_s_ready_drain"}, 80'(s_ready_a), 80'd0);
      tick();
      lat++;
    end
    chk({name, "_latency"}, 80'(lat), 80'd2);
    chk({name, "_acc"},     80'(m_acc_a), 80'(e_acc));
    chk({name, "_count"},   80'(m_count_a), 80'(e_cnt));
    chk({name, "_ovf"},     80'(m_ovf_a), 80'(e_ovf));
    chk({name, "_s_ready_done"}, 80'(s_ready_a), 80'd0);
  endtask

  task automatic handshake(input string name);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk({name, "_m_valid_drop"}, 80'(m_valid_a), 80'd0);
    chk({name, "_s_ready_back"}, 80'(s_ready_a), 80'd1);
  endtask

  task automatic run_vec(input int n, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < n; i++) send_beat(a, b, (i == n - 1));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    logic [71:0] exp_acc;
    logic [15:0] exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{32'd1, 32'd2, 1'b0, 72'd0, 16'd0, 1'b0};
    tbl[1] = '{32'd3, 32'd4, 1'b0, 72'd0, 16'd0, 1'b0};
    tbl[2] = '{32'd5, 32'd6, 1'b0, 72'd0, 16'd0, 1'b0};
    tbl[3] = '{32'd7, 32'd8, 1'b1, 72'd100, 16'd4, 1'b0};
    tbl[4] = '{32'd3, 32'd5, 1'b1, 72'd15, 16'd1, 1'b0};
    tbl[5] = '{32'h0000_FFFF, 32'h0001_0000, 1'b0, 72'd0, 16'd0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'd2, 1'b1, 72'h1_FFFF_0000, 16'd2, 1'b0};
    tbl[7] = '{32'd0, 32'hFFFF_FFFF, 1'b1, 72'd0, 16'd1, 1'b0};

    rstn = 1'b0; clr = 1'b0; s_valid = 1'b0; s_a = 32'd0; s_b = 32'd0;
    s_last = 1'b0; m_ready = 1'b0;

    // Reset state
    tick();
    s_valid = 1'b1; s_a = 32'd7; s_b = 32'd9;
    #1;
    chk("rst_s_ready", 80'(s_ready_a), 80'd0);
    chk("rst_mul_in1", 80'(mul_in1_a), 80'd0);
    chk("rst_m_valid", 80'(m_valid_a), 80'd0);
    chk("rst_m_acc",   80'(m_acc_a), 80'd0);
    s_valid = 1'b0; s_a = 32'd0; s_b = 32'd0;
    tick();
    #2 rstn = 1'b1;
    #1;
    chk("post_rst_s_ready", 80'(s_ready_a), 80'd1);
    tick();

    // Back-to-back beats from the table
    for (int i = 0; i < 8; i++) begin
      send_beat(tbl[i].a, tbl[i].b, tbl[i].last);
      if (tbl[i].last) begin
        wait_done($sformatf("tbl%0d", i), tbl[i].exp_acc, tbl[i].exp_cnt, tbl[i].exp_ovf);
        handshake($sformatf("tbl%0d", i));
      end
    end

    // Result held while m_ready is low, then next vector starts from zero
    send_beat(32'd6, 32'd7, 1'b1);
    wait_done("hold", 72'd42, 16'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_m_valid", 80'(m_valid_a), 80'd1);
      chk("hold_acc",     80'(m_acc_a), 80'd42);
      chk("hold_count",   80'(m_count_a), 80'd1);
      chk("hold_s_ready", 80'(s_ready_a), 80'd0);
    end
    handshake("hold");
    send_beat(32'd1, 32'd1, 1'b1);
    wait_done("after_hold", 72'd1, 16'd1, 1'b0);
    handshake("after_hold");

    // 256 max products fit in 72 bits; the 257th carries out and wraps
    run_vec(256, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max256", 72'hFF_FFFF_FE00_0000_0100, 16'd256, 1'b0);
    handshake("max256");
    run_vec(257, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max257", 72'h00_FFFF_FDFE_0000_0101, 16'd257, 1'b1);
    handshake("max257");

    // Two max products overflow a 64-bit accumulator but not a 72-bit one
    run_vec(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max2", 72'h1_FFFF_FFFC_0000_0002, 16'd2, 1'b0);
    chk("acc64_m_valid", 80'(m_valid_b), 80'd1);
    chk("acc64_acc",     80'(m_acc_b), 80'h0_FFFF_FFFC_0000_0002);
    chk("acc64_ovf",     80'(m_ovf_b), 80'd1);
    handshake("max2");

    // Counter saturation on the 2-bit-counter instance
    run_vec(5, 32'd1, 32'd1);
    wait_done("sat5", 72'd5, 16'd5, 1'b0);
    chk("cnt2_count", 80'(m_count_b), 80'd3);
    chk("cnt2_ovf",   80'(m_ovf_b), 80'd1);
    chk("cnt2_acc",   80'(m_acc_b), 80'd5);
    handshake("sat5");

    // clr while a product is in flight
    send_beat(32'd9, 32'd9, 1'b0);
    clr = 1'b1;
    s_valid = 1'b1; s_a = 32'd3; s_b = 32'd3;
    #1;
    chk("clr_s_ready", 80'(s_ready_a), 80'd0);
    chk("clr_mul_in1", 80'(mul_in1_a), 80'd0);
    s_valid = 1'b0; s_a = 32'd0; s_b = 32'd0;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clr_m_valid", 80'(m_valid_a), 80'd0);
      chk("clr_m_acc",   80'(m_acc_a), 80'd0);
      tick();
    end
    send_beat(32'd2, 32'd2, 1'b1);
    wait_done("after_clr", 72'd4, 16'd1, 1'b0);
    handshake("after_clr");

    // Reset pulsed in DRAIN discards the vector
    send_beat(32'd4, 32'd4, 1'b1);
    chk("drain_s_ready", 80'(s_ready_a), 80'd0);
    rstn = 1'b0;
    s_valid = 1'b1; s_a = 32'd5; s_b = 32'd5;
    #1;
    chk("midrst_m_acc",   80'(m_acc_a), 80'd0);
    chk("midrst_m_count", 80'(m_count_a), 80'd0);
    chk("midrst_m_valid", 80'(m_valid_a), 80'd0);
    chk("midrst_m_ovf",   80'(m_ovf_a), 80'd0);
    chk("midrst_s_ready", 80'(s_ready_a), 80'd0);
    chk("midrst_mul_in2", 80'(mul_in2_a), 80'd0);
    s_valid = 1'b0; s_a = 32'd0; s_b = 32'd0;
    tick();
    tick();
    #2 rstn = 1'b1;
    #1;
    chk("midrst_release_s_ready", 80'(s_ready_a), 80'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_result", 80'(m_valid_a), 80'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
